// File: rtl/mult_rr_scheduler_pkg.sv
// Shared definitions for the round-robin multiplier scheduler.
// Holds parameter defaults, the id-width derivation and the operand slice helper.
package mult_rr_scheduler_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int NUM_REQ_DEF    = 4;
    localparam int CNT_WIDTH_DEF  = 16;

    // Ceiling log2 for n >= 2; sizes the requester id.
    function automatic int clog2_f(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

    // LSB position of requester idx inside a packed operand bus.
    function automatic int op_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/mult_rr_scheduler_if.sv
// Request/response bundle between the fetch units and the multiplier scheduler.
// master: requester/consumer side, slave: scheduler side.
interface mult_rr_scheduler_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = 2
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
    logic                          rsp_valid;
    logic                          rsp_ready;
    logic [2*DATA_WIDTH-1:0]       rsp_data;
    logic [ID_WIDTH-1:0]           rsp_id;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id
    );
endinterface

// File: rtl/mult_rr_scheduler_arbiter.sv
// Round-robin winner select: first valid requester at or after rr_ptr, with wrap.
// Purely combinational; readiness gating is applied by the caller.
module mult_rr_arbiter
    import mult_rr_scheduler_pkg::*;
#(
    parameter int NUM_REQ  = NUM_REQ_DEF,
    parameter int ID_WIDTH = clog2_f(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  i_req_valid,
    input  logic [ID_WIDTH-1:0] i_rr_ptr,
    output logic [NUM_REQ-1:0]  o_grant,
    output logic [ID_WIDTH-1:0] o_grant_id
);

    int w_idx;

    // scan offsets from far to near so the nearest valid requester wins last
    always_comb begin
        o_grant    = '0;
        o_grant_id = '0;
        w_idx      = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = (int'(i_rr_ptr) + k) % NUM_REQ;
            if (i_req_valid[w_idx]) begin
                o_grant        = '0;
                o_grant[w_idx] = 1'b1;
                o_grant_id     = ID_WIDTH'(w_idx);
            end
        end
    end

endmodule

// File: rtl/vedicmultiplier_8bit.sv
// Combinational 8x8 unsigned multiplier built Urdhva-Tiryagbhyam style:
// 2x2 vertical/crosswise cells combined into 4x4, then into 8x8.
module vedicmultiplier_8bit (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] prod
);

    function automatic logic [3:0] v2(input logic [1:0] x, input logic [1:0] y);
        logic c;
        logic [3:0] p;
        p[0] = x[0] & y[0];
        p[1] = (x[1] & y[0]) ^ (x[0] & y[1]);
        c    = (x[1] & y[0]) & (x[0] & y[1]);
        p[2] = (x[1] & y[1]) ^ c;
        p[3] = (x[1] & y[1]) & c;
        return p;
    endfunction

    function automatic logic [7:0] v4(input logic [3:0] x, input logic [3:0] y);
        logic [3:0] q0, q1, q2, q3;
        q0 = v2(x[1:0], y[1:0]);
        q1 = v2(x[3:2], y[1:0]);
        q2 = v2(x[1:0], y[3:2]);
        q3 = v2(x[3:2], y[3:2]);
        return {4'b0, q0} + {2'b0, q1, 2'b0} + {2'b0, q2, 2'b0} + {q3, 4'b0};
    endfunction

    logic [7:0] w_q0, w_q1, w_q2, w_q3;

    // crosswise partial products of the nibbles
    always_comb begin
        w_q0 = v4(a[3:0], b[3:0]);
        w_q1 = v4(a[7:4], b[3:0]);
        w_q2 = v4(a[3:0], b[7:4]);
        w_q3 = v4(a[7:4], b[7:4]);
    end

    assign prod = {8'b0, w_q0} + {4'b0, w_q1, 4'b0} + {4'b0, w_q2, 4'b0} + {w_q3, 8'b0};

endmodule

// File: rtl/mult_rr_scheduler.sv
// Round-robin scheduler sharing one vedicmultiplier_8bit between NUM_REQ requesters.
// Two registered stages (issue, result); one product per cycle at full rate.
// Optional macro MULT_SCHED_STATS_EN adds saturating per-requester grant counters.
module mult_rr_scheduler
    import mult_rr_scheduler_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int NUM_REQ    = NUM_REQ_DEF,
    parameter int ID_WIDTH   = clog2_f(NUM_REQ)
`ifdef MULT_SCHED_STATS_EN
  , parameter int CNT_WIDTH  = CNT_WIDTH_DEF
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mult_rr_scheduler_if.slave    bus
`ifdef MULT_SCHED_STATS_EN
  , output logic [NUM_REQ*CNT_WIDTH-1:0] grant_count
`endif
);

    logic [ID_WIDTH-1:0]     r_rr_ptr;
    logic                    r_s1_valid;
    logic [DATA_WIDTH-1:0]   r_s1_a;
    logic [DATA_WIDTH-1:0]   r_s1_b;
    logic [ID_WIDTH-1:0]     r_s1_id;
    logic                    r_s2_valid;
    logic [2*DATA_WIDTH-1:0] r_s2_data;
    logic [ID_WIDTH-1:0]     r_s2_id;

    logic [NUM_REQ-1:0]      w_grant;
    logic [ID_WIDTH-1:0]     w_grant_id;
    logic                    w_s2_free;
    logic                    w_s1_free;
    logic                    w_s1_move;
    logic [NUM_REQ-1:0]      w_xfer_vec;
    logic                    w_xfer;
    logic [DATA_WIDTH-1:0]   w_sel_a;
    logic [DATA_WIDTH-1:0]   w_sel_b;
    logic [2*DATA_WIDTH-1:0] w_prod;

    mult_rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_arb (
        .i_req_valid (bus.req_valid),
        .i_rr_ptr    (r_rr_ptr),
        .o_grant     (w_grant),
        .o_grant_id  (w_grant_id)
    );

    vedicmultiplier_8bit u_mult (
        .a    (r_s1_a),
        .b    (r_s1_b),
        .prod (w_prod)
    );

    // rst_n gates readiness so nothing is accepted while reset is held
    assign w_s2_free  = !r_s2_valid || bus.rsp_ready;
    assign w_s1_free  = (!r_s1_valid || w_s2_free) && rst_n;
    assign w_s1_move  = r_s1_valid && w_s2_free;
    assign w_xfer_vec = bus.req_valid & bus.req_ready;
    assign w_xfer     = |w_xfer_vec;
    assign w_sel_a    = bus.req_a[op_lsb(int'(w_grant_id), DATA_WIDTH) +: DATA_WIDTH];
    assign w_sel_b    = bus.req_b[op_lsb(int'(w_grant_id), DATA_WIDTH) +: DATA_WIDTH];

    assign bus.req_ready = w_grant & {NUM_REQ{w_s1_free}};
    assign bus.rsp_valid = r_s2_valid;
    assign bus.rsp_data  = r_s2_data;
    assign bus.rsp_id    = r_s2_id;

    // issue stage: capture the granted operands and advance the round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_id    <= '0;
            r_rr_ptr   <= '0;
        end else begin
            r_s1_valid <= w_xfer || (r_s1_valid && !w_s2_free);
            if (w_xfer) begin
                r_s1_a   <= w_sel_a;
                r_s1_b   <= w_sel_b;
                r_s1_id  <= w_grant_id;
                r_rr_ptr <= (w_grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0
                                                                   : w_grant_id + ID_WIDTH'(1);
            end
        end
    end

    // result stage: register the product; hold while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_id    <= '0;
        end else begin
            r_s2_valid <= w_s1_move || (r_s2_valid && !bus.rsp_ready);
            if (w_s1_move) begin
                r_s2_data <= w_prod;
                r_s2_id   <= r_s1_id;
            end
        end
    end

`ifdef MULT_SCHED_STATS_EN
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cnt
        logic [CNT_WIDTH-1:0] r_cnt;

        // count transfers per requester, sticking at all-ones
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt <= '0;
            end else if (w_xfer_vec[gi] && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign grant_count[gi*CNT_WIDTH +: CNT_WIDTH] = r_cnt;
    end
`endif

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Self-checking bench for mult_rr_scheduler: directed steps plus random traffic
// compared against a transaction-level model (in-order queue, capacity two).
module tb_mult_rr_scheduler;

`ifdef MULT_SCHED_STATS_EN
    localparam int CW = 4;
`endif

    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0]  id;
        logic [15:0] data;
        int          acc;
    } item_t;

    item_t      q[$];
    int         ptr;
    int         cyc;
    int         exp_cnt[4];
    logic [3:0] obs_ready;

    mult_rr_scheduler_if #(.DATA_WIDTH(8), .NUM_REQ(4), .ID_WIDTH(2)) bus ();

`ifdef MULT_SCHED_STATS_EN
    logic [4*CW-1:0] grant_count;
    mult_rr_scheduler #(.DATA_WIDTH(8), .NUM_REQ(4), .ID_WIDTH(2), .CNT_WIDTH(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .grant_count (grant_count)
    );
`else
    mult_rr_scheduler #(.DATA_WIDTH(8), .NUM_REQ(4), .ID_WIDTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [7:0] a, input logic [7:0] b);
        bus.req_valid[i]       = v;
        bus.req_a[i*8 +: 8]    = a;
        bus.req_b[i*8 +: 8]    = b;
    endtask

    task automatic clear_req();
        bus.req_valid = '0;
    endtask

    // One clock: check outputs at the falling edge, then advance the model on the rising edge.
    task automatic step();
        int          win;
        int          idx;
        logic        s1free;
        logic [3:0]  er;
        logic        ev;
        logic [7:0]  ea;
        logic [7:0]  eb;
        item_t       it;
        @(negedge clk);
        win = -1;
        for (int k = 0; k < 4; k++) begin
            idx = (ptr + k) % 4;
            if (bus.req_valid[idx] && win < 0) win = idx;
        end
        s1free = (q.size() < 2) || bus.rsp_ready;
        er = 4'b0;
        if (win >= 0 && s1free) er[win] = 1'b1;
        ev = (q.size() > 0) && (cyc > q[0].acc);
        obs_ready = bus.req_ready;
        chk("req_ready", 32'(bus.req_ready), 32'(er));
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(ev));
        if (ev) begin
            chk("rsp_data", 32'(bus.rsp_data), 32'(q[0].data));
            chk("rsp_id", 32'(bus.rsp_id), 32'(q[0].id));
        end
`ifdef MULT_SCHED_STATS_EN
        for (int i = 0; i < 4; i++)
            chk("grant_count", 32'(grant_count[i*CW +: CW]), 32'(exp_cnt[i]));
`endif
        @(posedge clk);
        cyc++;
        if (ev && bus.rsp_ready) void'(q.pop_front());
        if (er != 0) begin
            ea      = bus.req_a[win*8 +: 8];
            eb      = bus.req_b[win*8 +: 8];
            it.id   = 2'(win);
            it.data = 16'(ea) * 16'(eb);
            it.acc  = cyc;
            q.push_back(it);
            ptr = (win + 1) % 4;
`ifdef MULT_SCHED_STATS_EN
            if (exp_cnt[win] < (1 << CW) - 1) exp_cnt[win]++;
`endif
        end
        #1;
    endtask

    // Assert reset away from clock edges, check outputs drop at once, release after a rising edge.
    task automatic do_reset();
        #3 rst_n = 1'b0;
        #1;
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
        q.delete();
        ptr = 0;
        for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
        clear_req();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic rand_drive();
        for (int i = 0; i < 4; i++) begin
            if (!(bus.req_valid[i] && !obs_ready[i]))
                set_req(i, ($urandom_range(0, 9) < 6), 8'($urandom), 8'($urandom));
        end
        bus.rsp_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic drain();
        clear_req();
        bus.rsp_ready = 1'b1;
        repeat (3) step();
    endtask

    logic [15:0] exp_prod[4];
    logic [3:0]  exp_order[6];
    int          acc_cnt;

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = 4'hF;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;
        ptr = 0;
        cyc = 0;
        obs_ready = '0;
        for (int i = 0; i < 4; i++) exp_cnt[i] = 0;

        // reset state, with requests pending
        #12;
        chk("rst_req_ready_held", 32'(bus.req_ready), 32'd0);
        do_reset();

        // all requesters continuously valid: grant order and back-to-back products
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 8'(i + 1), 8'h10);
        exp_order[0] = 4'b0001; exp_order[1] = 4'b0010; exp_order[2] = 4'b0100;
        exp_order[3] = 4'b1000; exp_order[4] = 4'b0001; exp_order[5] = 4'b0010;
        exp_prod[0] = 16'h0010; exp_prod[1] = 16'h0020;
        exp_prod[2] = 16'h0030; exp_prod[3] = 16'h0040;
        for (int s = 0; s < 6; s++) begin
            step();
            chk("grant_order", 32'(obs_ready), 32'(exp_order[s]));
            if (s >= 1 && s <= 4) begin
                chk("b2b_valid", 32'(bus.rsp_valid), 32'd1);
                chk("b2b_data", 32'(bus.rsp_data), 32'(exp_prod[s-1]));
            end
        end
        drain();

        // single request from requester 2
        set_req(2, 1'b1, 8'h0D, 8'h0B);
        step();
        clear_req();
        step();
        chk("single_valid", 32'(bus.rsp_valid), 32'd1);
        chk("single_data", 32'(bus.rsp_data), 32'h008F);
        chk("single_id", 32'(bus.rsp_id), 32'd2);
        drain();

        // operand extremes from requester 0
        set_req(0, 1'b1, 8'hFF, 8'hFF);
        step();
        set_req(0, 1'b1, 8'h00, 8'hA5);
        step();
        clear_req();
        chk("max_data", 32'(bus.rsp_data), 32'hFE01);
        step();
        chk("zero_data", 32'(bus.rsp_data), 32'h0000);
        chk("zero_valid", 32'(bus.rsp_valid), 32'd1);
        drain();

        // backpressure: requester 1 streams while the consumer stalls
        bus.rsp_ready = 1'b0;
        set_req(1, 1'b1, 8'($urandom), 8'($urandom));
        acc_cnt = 0;
        repeat (5) begin
            step();
            if (obs_ready[1]) begin
                acc_cnt++;
                set_req(1, 1'b1, 8'($urandom), 8'($urandom));
            end
        end
        chk("bp_accepts", 32'(acc_cnt), 32'd2);
        chk("bp_ready_low", 32'(obs_ready), 32'd0);
        bus.rsp_ready = 1'b1;
        repeat (3) begin
            step();
            if (obs_ready[1]) set_req(1, 1'b1, 8'($urandom), 8'($urandom));
        end
        drain();

        // random traffic against the model
        for (int s = 0; s < 400; s++) begin
            rand_drive();
            step();
        end
        drain();

        // reset with both stages full
        bus.rsp_ready = 1'b0;
        set_req(0, 1'b1, 8'($urandom), 8'($urandom));
        repeat (3) begin
            step();
            if (obs_ready[0]) set_req(0, 1'b1, 8'($urandom), 8'($urandom));
        end
        chk("full_before_rst", 32'(q.size()), 32'd2);
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 8'($urandom), 8'($urandom));
        bus.rsp_ready = 1'b1;
        step();
        chk("post_rst_first_grant", 32'(obs_ready), 32'b0001);
        repeat (3) step();
        drain();

`ifdef MULT_SCHED_STATS_EN
        // saturating grant counter on requester 3
        do_reset();
        set_req(3, 1'b1, 8'h03, 8'h07);
        repeat (20) step();
        drain();
        chk("cnt3_sat", 32'(grant_count[3*CW +: CW]), 32'hF);
        for (int i = 0; i < 3; i++)
            chk("cnt_other_zero", 32'(grant_count[i*CW +: CW]), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
